// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin word scheduler and frame sequencer for a PISO shift register.
// Define PISO_TX_PARITY_EN to append an even-parity bit, making each frame WIDTH+1 cycles.
module piso_tx_sched #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2,
  parameter int SRCW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  piso_load,
  output logic [WIDTH-1:0]      piso_data,
  input  logic                  piso_serial,
  output logic                  ser_valid,
  output logic                  ser_data,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic [SRCW-1:0]       ser_src,
  output logic                  busy
);

`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int              CNTW     = $clog2(FL);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(FL - 1);
  localparam logic [0:0]      IDLE     = 1'b0;
  localparam logic [0:0]      SHIFT    = 1'b1;

  function automatic logic [SRCW-1:0] wrap_idx(input logic [SRCW-1:0] base, input int step);
    wrap_idx = SRCW'((int'(base) + step) % NREQ);
  endfunction

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    even_parity = ^word;
  endfunction

  logic [0:0]       state_r;
  logic [CNTW-1:0]  bit_cnt_r;
  logic [SRCW-1:0]  last_grant_r;
  logic [SRCW-1:0]  ser_src_r;
  logic [WIDTH-1:0] req_word_s [NREQ];
  logic             grant_found_s;
  logic [SRCW-1:0]  grant_idx_s;
  logic             in_shift_s;
  logic             frame_end_s;
  logic             accept_s;
  logic             grant_s;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_word_s[i] = req_data[i*WIDTH +: WIDTH];
  end

  assign in_shift_s  = (state_r == SHIFT);
  assign frame_end_s = in_shift_s && (bit_cnt_r == LAST_CNT);
  // rst_n gating keeps the combinational strobes quiet while reset is held.
  assign accept_s    = rst_n && (!in_shift_s || frame_end_s);
  assign grant_s     = accept_s && grant_found_s;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found_s && req_valid[wrap_idx(last_grant_r, k)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = wrap_idx(last_grant_r, k);
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Accept handshake and shift-register load, all in the grant cycle.
  always_comb begin
    if (grant_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
      piso_load = 1'b1;
      piso_data = req_word_s[grant_idx_s];
    end else begin
      req_ready = '0;
      piso_load = 1'b0;
      piso_data = '0;
    end
  end

`ifdef PISO_TX_PARITY_EN
  logic parity_r;

  // Parity of the granted word, replayed on the trailing frame cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if (grant_s) begin
      parity_r <= even_parity(req_word_s[grant_idx_s]);
    end else begin
      parity_r <= parity_r;
    end
  end

  // Serial bit: shifter output for data positions, parity on the trailer.
  always_comb begin
    if (frame_end_s) begin
      ser_data = parity_r;
    end else if (in_shift_s) begin
      ser_data = piso_serial;
    end else begin
      ser_data = 1'b0;
    end
  end
`else
  // Serial bit passes straight through from the shifter while framing.
  always_comb begin
    if (in_shift_s) begin
      ser_data = piso_serial;
    end else begin
      ser_data = 1'b0;
    end
  end
`endif

  // Frame sequencer: a grant at the last bit restarts the count with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= '0;
      last_grant_r <= SRCW'(NREQ - 1);
      ser_src_r    <= '0;
    end else if (grant_s) begin
      state_r      <= SHIFT;
      bit_cnt_r    <= '0;
      last_grant_r <= grant_idx_s;
      ser_src_r    <= grant_idx_s;
    end else if (frame_end_s) begin
      state_r      <= IDLE;
      bit_cnt_r    <= '0;
    end else if (in_shift_s) begin
      bit_cnt_r    <= bit_cnt_r + CNTW'(1);
    end else begin
      bit_cnt_r    <= bit_cnt_r;
    end
  end

  assign ser_valid = in_shift_s;
  assign busy      = in_shift_s;
  assign ser_first = in_shift_s && (bit_cnt_r == '0);
  assign ser_last  = frame_end_s;
  assign ser_src   = ser_src_r;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Testbench for piso_tx_sched: a vector table, directed corner sequences and randomized
// traffic, all compared against a frame-queue reference model.
module tb_piso_tx_sched;
  localparam int WIDTH = 16;
  localparam int NREQ  = 2;
  localparam int SRCW  = 1;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  piso_load;
  logic [WIDTH-1:0]      piso_data;
  logic                  piso_serial;
  logic                  ser_valid, ser_data, ser_first, ser_last, busy;
  logic [SRCW-1:0]       ser_src;
  logic [WIDTH-1:0]      sr = '0;

  piso_tx_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .piso_load(piso_load), .piso_data(piso_data),
    .piso_serial(piso_serial), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_first(ser_first), .ser_last(ser_last), .ser_src(ser_src), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shift register the scheduler drives: load wins, otherwise shift right with zero fill.
  always @(posedge clk) begin
    if (piso_load) sr <= piso_data;
    else           sr <= sr >> 1;
  end
  assign piso_serial = sr[0];

  // Reference model: each grant pushes the whole expected frame onto a bit queue.
  typedef struct packed {logic d; logic f; logic l; logic [SRCW-1:0] s;} bit_t;
  bit_t            exp_q[$];
  int              last_g = NREQ - 1;
  logic [SRCW-1:0] exp_src = '0;
  int              granted = -1;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    int g, idx;
    logic [NREQ-1:0]  er;
    logic [WIDTH-1:0] w;
    bit_t b;
    if (!rst_n) begin
      exp_q.delete();
      last_g  = NREQ - 1;
      exp_src = '0;
    end
    g = -1;
    if (rst_n && exp_q.size() <= 1) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (last_g + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    er = '0;
    w  = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      w     = req_data[g*WIDTH +: WIDTH];
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("piso_load", 32'(piso_load), 32'(g >= 0));
    chk("piso_data", 32'(piso_data), 32'(w));
    if (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      chk("ser_valid", 32'(ser_valid), 32'd1);
      chk("ser_data",  32'(ser_data),  32'(b.d));
      chk("ser_first", 32'(ser_first), 32'(b.f));
      chk("ser_last",  32'(ser_last),  32'(b.l));
      chk("ser_src",   32'(ser_src),   32'(b.s));
      chk("busy",      32'(busy),      32'd1);
    end else begin
      chk("idle_valid", 32'(ser_valid), 32'd0);
      chk("idle_data",  32'(ser_data),  32'd0);
      chk("idle_first", 32'(ser_first), 32'd0);
      chk("idle_last",  32'(ser_last),  32'd0);
      chk("idle_busy",  32'(busy),      32'd0);
      chk("idle_src",   32'(ser_src),   32'(exp_src));
    end
    if (g >= 0) begin
      for (int p = 0; p < FL; p++) begin
        b.d = (p < WIDTH) ? w[p] : ^w;
        b.f = (p == 0);
        b.l = (p == FL - 1);
        b.s = SRCW'(g);
        exp_q.push_back(b);
      end
      last_g  = g;
      exp_src = SRCW'(g);
    end
    granted = g;
  endtask

  task automatic cyc();
    #1;
    model_check();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0]  rv;
    logic [WIDTH-1:0] d0;
    logic [NREQ-1:0]  e_ready;
    logic             e_load, e_valid, e_data, e_first, e_last, e_busy;
  } vec_t;
  vec_t tbl[FL+2];

  logic [WIDTH-1:0] word;
  logic [NREQ-1:0]  exp_order[4];
  int               n;

  initial begin
    word   = 16'hA5C3;
    tbl[0] = '{2'b01, word, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 1; k <= FL; k++) begin
      tbl[k] = '{2'b00, word, 2'b00, 1'b0, 1'b1, (k <= WIDTH) ? word[k-1] : ^word,
                 k == 1, k == FL, 1'b1};
    end
    tbl[FL+1] = '{2'b00, word, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;

    @(negedge clk);
    do_reset();

    // Single word from requester 0, checked against the vector table.
    for (int i = 0; i < FL + 2; i++) begin
      req_valid = tbl[i].rv;
      req_data[WIDTH-1:0] = tbl[i].d0;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(tbl[i].e_ready));
      chk("tbl_load",  32'(piso_load), 32'(tbl[i].e_load));
      chk("tbl_valid", 32'(ser_valid), 32'(tbl[i].e_valid));
      chk("tbl_data",  32'(ser_data),  32'(tbl[i].e_data));
      chk("tbl_first", 32'(ser_first), 32'(tbl[i].e_first));
      chk("tbl_last",  32'(ser_last),  32'(tbl[i].e_last));
      chk("tbl_busy",  32'(busy),      32'(tbl[i].e_busy));
      model_check();
      @(negedge clk);
    end

    // Both requesters held valid: alternating grants, loads land on the prior ser_last.
    do_reset();
    req_valid = 2'b11;
    req_data  = {16'h8000, 16'h0001};
    n = 0;
    for (int c = 0; c < 4*FL - 1; c++) begin
      #1;
      if (piso_load) begin
        if (n < 4) chk("t2_order", 32'(req_ready), 32'(exp_order[n]));
        if (n > 0) chk("t2_load_on_last", 32'(ser_last), 32'd1);
        n++;
      end
      model_check();
      @(negedge clk);
    end
    chk("t2_grants", 32'(n), 32'd4);
    req_valid = 2'b00;
    for (int c = 0; c < FL + 2; c++) cyc();

    // Lone requester 1 is re-granted, then requester 0 wins the next accept point.
    req_valid = 2'b10;
    req_data[2*WIDTH-1:WIDTH] = 16'h1234;
    #1;
    chk("t3_regrant", 32'(req_ready), 32'(2'b10));
    model_check();
    @(negedge clk);
    req_valid = 2'b11;
    req_data[WIDTH-1:0] = 16'h00F0;
    for (int c = 0; c < FL - 1; c++) cyc();
    #1;
    chk("t3_rotate", 32'(req_ready), 32'(2'b01));
    model_check();
    @(negedge clk);
    req_valid = 2'b10;

    // Reset at bit_cnt 7 of requester 0's frame; requester 0 must win afterwards.
    for (int c = 0; c < 7; c++) cyc();
    chk("t4_in_frame", 32'(ser_valid), 32'd1);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(ser_valid), 32'd0);
    chk("t4_rst_last",  32'(ser_last),  32'd0);
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    chk("t4_rst_load",  32'(piso_load), 32'd0);
    chk("t4_rst_src",   32'(ser_src),   32'd0);
    model_check();
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("t4_first_grant", 32'(req_ready), 32'(2'b01));
    model_check();
    @(negedge clk);
    req_valid = 2'b00;
    for (int c = 0; c < FL + 2; c++) cyc();

    // Parity corner words 0x0007 and 0x0003 from requester 0.
    req_data[WIDTH-1:0] = 16'h0007;
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    for (int c = 0; c < FL; c++) cyc();
    req_data[WIDTH-1:0] = 16'h0003;
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    for (int c = 0; c < FL + 1; c++) cyc();

    // Randomized traffic; a requester drops valid only once accepted.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      cyc();
      if (granted >= 0) req_valid[granted] = 1'b0;
    end

    // Idle stretch: nothing accepted or emitted, ser_src holds.
    req_valid = 2'b00;
    for (int c = 0; c < FL + 2; c++) cyc();
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("t6_ready", 32'(req_ready), 32'd0);
      chk("t6_load",  32'(piso_load), 32'd0);
      chk("t6_valid", 32'(ser_valid), 32'd0);
      model_check();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
